// File: rtl/gru_pkg.sv
// gru_pkg: widths, layer lengths, float constants and loader state type shared by the GRU blocks
package gru_pkg;
  localparam int FLOAT_W = 32;
  localparam int GRU1_LEN = 24;
  localparam int GRU2_LEN = 90;
  localparam int GRU3_LEN = 114;
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] WEIGHTS_SCALE = 32'h3B800000;
  typedef enum logic {FILL, DISCARD} ld_state_t;
endpackage

// File: rtl/gru_vec_bank.sv
// gru_vec_bank: one vector bank with indexed word write and a full flag that locks out writes
module gru_vec_bank import gru_pkg::*; #(
  parameter int FLOAT = FLOAT_W,
  parameter int LEN = GRU1_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [7:0]           widx,
  input  logic [FLOAT-1:0]     wdata,
  input  logic                 set_full,
  input  logic                 clr_full,
  output logic [LEN*FLOAT-1:0] data,
  output logic                 full
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      for (int k = 0; k < LEN; k++)
        if (we && !full && widx == 8'(k)) data[k*FLOAT +: FLOAT] <= wdata;
      full <= set_full | (full & ~clr_full);
    end
endmodule

// File: rtl/gru_vec_loader.sv
// gru_vec_loader: ping-pong stream-to-vector loader with in_last frame checking
module gru_vec_loader import gru_pkg::*; #(
  parameter int FLOAT = FLOAT_W,
  parameter int LEN = GRU1_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLOAT-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [LEN*FLOAT-1:0] vec_data,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic                 frame_err,
  output logic [7:0]           fill_count
);
  ld_state_t state, state_nx;
  logic [7:0] idx, idx_nx;
  logic wr_sel, rd_sel, acc, at_end, we, commit, rel, err;
  logic [1:0] full;
  logic [LEN*FLOAT-1:0] bank_data [2];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    gru_vec_bank #(.FLOAT(FLOAT), .LEN(LEN)) u_bank (
      .clk(clk),
      .rst_n(rst_n),
      .we(we && wr_sel == 1'(b)),
      .widx(idx),
      .wdata(in_data),
      .set_full(commit && wr_sel == 1'(b)),
      .clr_full(rel && rd_sel == 1'(b)),
      .data(bank_data[b]),
      .full(full[b])
    );
  end
  assign vec_valid = full[rd_sel];
  assign vec_data = bank_data[rd_sel];
  assign fill_count = idx;
  always_comb begin
    in_ready = state == DISCARD || !full[wr_sel];
    acc = in_valid && in_ready;
    at_end = idx == 8'(LEN-1);
    we = acc && state == FILL;
    commit = we && at_end && in_last;
    err = we && (at_end ^ in_last);
    rel = vec_valid && vec_ready;
    idx_nx = !we ? idx : (at_end || in_last) ? 8'd0 : idx + 8'd1;
    state_nx = (we && at_end && !in_last) ? DISCARD :
               (state == DISCARD && acc && in_last) ? FILL : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      idx <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      wr_sel <= wr_sel ^ commit;
      rd_sel <= rd_sel ^ rel;
      frame_err <= err;
    end
endmodule
